gp_register_file: RTL and testbench
===================================

Name: gp_register_file

Overview:
- Parametrised successor to the fixed X/Y/accumulator register block.
- Holds NUM_REGS general registers of DATA_W bits, plus a dedicated accumulator with two write sources (memory, ALU).
- Provides two independent combinational read ports with optional write bypass.
- Adds a one-deep shadow bank: context save/restore for interrupt entry/exit in the GPP control path.

Parameters:
- DATA_W, 16, register and accumulator width in bits.
- NUM_REGS, 4, number of general registers; legal range 2..16.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, do not override.
- BYPASS, 1, when 1 a same-cycle write to the addressed register is forwarded to the read ports.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active low.
- wr_en  input  1  general register write enable.
- wr_addr  input  ADDR_W  general register write address.
- wr_data  input  DATA_W  general register write data.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_b  output  DATA_W  read port B data (combinational).
- acc_wr_mem  input  1  load accumulator from acc_din_mem.
- acc_din_mem  input  DATA_W  accumulator data from memory.
- acc_wr_alu  input  1  load accumulator from acc_din_alu.
- acc_din_alu  input  DATA_W  accumulator data from ALU.
- acc_out  output  DATA_W  accumulator value (registered state).
- acc_zero  output  1  registered flag, 1 when accumulator is 0.
- ctx_save  input  1  pulse: copy all registers and accumulator to the shadow bank.
- ctx_restore  input  1  pulse: copy the shadow bank back to the live registers.
- shadow_valid  output  1  shadow bank holds a saved context.
- restore_err  output  1  one-cycle pulse: restore requested with shadow_valid=0.

Behaviour:
- Clock and reset: single clock, clk. rst is asynchronous and active-low.
- Reset values: all registers, accumulator and shadow contents 0; acc_zero=1; shadow_valid=0; restore_err=0. Read ports therefore return 0.
- Writes take effect at the clk edge while wr_en=1.
- wr_addr >= NUM_REGS: write ignored, no state change.
- rd_addr >= NUM_REGS: read returns 0.
- Read ports are combinational with 0-cycle latency. Both ports may address the same register.
- BYPASS=1 and wr_en=1 with wr_addr==rd_addr_x: rd_data_x = wr_data in that cycle.
- BYPASS=0: read returns the pre-edge value.
- Accumulator sources: acc_wr_mem loads acc_din_mem; acc_wr_alu loads acc_din_alu.
- Both asserted in one cycle: ALU wins.
- acc_zero is updated at the same edge as the accumulator and reflects the new value.
- ctx_save: at the edge, the shadow bank captures the pre-edge values of all registers and the accumulator; shadow_valid<=1.
  - A write in the same cycle still updates the live register.
  - The shadow holds the old value.
  - A second save overwrites the shadow.
- ctx_restore with shadow_valid=1: at the edge, live registers and accumulator <= shadow; acc_zero recomputed from the shadow accumulator; shadow_valid<=0.
  - Restore overrides any same-cycle wr_en or accumulator write; those writes are dropped.
- ctx_restore with shadow_valid=0: no state change; restore_err=1 for exactly one cycle.
- ctx_save and ctx_restore together: restore executes as above (or flags an error); save is ignored; shadow_valid ends 0 when the restore succeeds.
- Reset asserted mid-operation clears everything immediately, including shadow_valid.

Decomposition:
- Package gpr_pkg holds:
  - default DATA_W and NUM_REGS constants;
  - a typedef for the register word;
  - a typedef for the context struct (register array plus accumulator), shared by the top level and the shadow bank.
- Sub-module gpr_shadow_bank holds the saved context and shadow_valid.
  - Inputs: save, restore, live context.
  - Outputs: saved context, valid, restore_err.
  - The top level muxes its restore data into the live registers.

Test Plan:
- Reset, then write 16'hA5A5 to r1 and 16'h5A5A to r2; read r1 on A and r2 on B -> A5A5 and 5A5A; rd_addr=NUM_REGS -> 0000.
- BYPASS=1: wr r3=16'hBEEF with rd_addr_a=3 in the same cycle -> rd_data_a=BEEF before the edge. Rerun with BYPASS=0 -> old value 0000 until after the edge.
- Accumulator priority: acc_wr_mem=1 (1234) with acc_wr_alu=1 (0000) -> acc_out=0000, acc_zero=1. Next cycle mem only, 1234 -> acc_out=1234, acc_zero=0.
- Context: r1=1111, acc=2222, then ctx_save; write r1=FACE and acc=0BAD; ctx_restore -> r1=1111, acc=2222, shadow_valid 1->0.
- Error paths:
  - ctx_restore with shadow_valid=0 -> one-cycle restore_err, registers unchanged.
  - Save and restore in the same cycle after a valid save -> restore applied, shadow_valid=0.
- Reset during save: assert rst mid-cycle after r1=FACE and ctx_save -> all outputs 0, shadow_valid=0, acc_zero=1.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants and types for the general-purpose register file.
// Latency, backpressure: none. This package holds declarations only.
package gpr_pkg;

  localparam int GPR_DATA_W   = 16;
  localparam int GPR_NUM_REGS = 4;

  typedef logic [GPR_DATA_W-1:0] word_t;

  // Context layout at the default sizes: the general registers plus the accumulator.
  typedef struct packed {
    word_t [GPR_NUM_REGS-1:0] regs;
    word_t                    acc;
  } ctx_t;

endpackage

// File: rtl/gpr_shadow_bank.sv
// Holds one saved context and a valid flag. Save and restore act at the clock edge.
// Backpressure: none. A restore with no saved context produces a one-cycle restore_err.
module gpr_shadow_bank
  import gpr_pkg::*;
#(
  parameter type ctx_type_t = ctx_t
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      save,
  input  logic      restore,
  input  ctx_type_t live,
  output ctx_type_t saved,
  output logic      valid,
  output logic      restore_err
);

  // Restore takes precedence over save. A simultaneous save is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      saved       <= '0;
      valid       <= 1'b0;
      restore_err <= 1'b0;
    end else begin
      restore_err <= restore & ~valid;
      if (restore) begin
        valid <= 1'b0;
      end else if (save) begin
        saved <= live;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gp_register_file.sv
// NUM_REGS general registers, an accumulator and a shadow bank for context save and restore.
// Reads are combinational with 0-cycle latency; writes act at the edge. Backpressure: none.
module gp_register_file
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              acc_wr_mem,
  input  logic [DATA_W-1:0] acc_din_mem,
  input  logic              acc_wr_alu,
  input  logic [DATA_W-1:0] acc_din_alu,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_zero,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  output logic              shadow_valid,
  output logic              restore_err
);

  // Same layout as gpr_pkg::ctx_t, but sized from this instance's parameters.
  typedef logic [DATA_W-1:0] rf_word_t;
  typedef struct packed {
    rf_word_t [NUM_REGS-1:0] regs;
    rf_word_t                acc;
  } rf_ctx_t;

  rf_ctx_t live;
  rf_ctx_t saved;
  logic    restore_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NUM_REGS;
  endfunction

  gpr_shadow_bank #(
    .ctx_type_t(rf_ctx_t)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .save       (ctx_save),
    .restore    (ctx_restore),
    .live       (live),
    .saved      (saved),
    .valid      (shadow_valid),
    .restore_err(restore_err)
  );

  assign restore_ok = ctx_restore & shadow_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live     <= '0;
      acc_zero <= 1'b1;
    end else if (restore_ok) begin
      // A successful restore drops every write issued in the same cycle.
      live     <= saved;
      acc_zero <= (saved.acc == '0);
    end else begin
      if (wr_en && in_range(wr_addr)) begin
        live.regs[wr_addr] <= wr_data;
      end
      if (acc_wr_alu) begin
        live.acc <= acc_din_alu;
        acc_zero <= (acc_din_alu == '0);
      end else if (acc_wr_mem) begin
        live.acc <= acc_din_mem;
        acc_zero <= (acc_din_mem == '0);
      end
    end
  end

  assign acc_out = live.acc;

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (in_range(rd_addr_a)) begin
      rd_data_a = live.regs[rd_addr_a];
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr_a) begin
        rd_data_a = wr_data;
      end
    end
    if (in_range(rd_addr_b)) begin
      rd_data_b = live.regs[rd_addr_b];
      if (BYPASS != 0 && wr_en && wr_addr == rd_addr_b) begin
        rd_data_b = wr_data;
      end
    end
  end

endmodule

// File: tb/tb_gp_register_file.sv
// Directed bench for gp_register_file. It drives the BYPASS=1 and BYPASS=0 instances in parallel.
module tb_gp_register_file;

  localparam int DW = 16;
  localparam int NR = 5;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          acc_wr_mem;
  logic [DW-1:0] acc_din_mem;
  logic          acc_wr_alu;
  logic [DW-1:0] acc_din_alu;
  logic          ctx_save;
  logic          ctx_restore;

  logic [DW-1:0] rda1, rdb1, acc1, rda0, rdb0, acc0;
  logic          accz1, sv1, rerr1, accz0, sv0, rerr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gp_register_file #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
    .acc_wr_mem(acc_wr_mem), .acc_din_mem(acc_din_mem),
    .acc_wr_alu(acc_wr_alu), .acc_din_alu(acc_din_alu),
    .acc_out(acc1), .acc_zero(accz1), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .shadow_valid(sv1), .restore_err(rerr1)
  );

  gp_register_file #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
    .acc_wr_mem(acc_wr_mem), .acc_din_mem(acc_din_mem),
    .acc_wr_alu(acc_wr_alu), .acc_din_alu(acc_din_alu),
    .acc_out(acc0), .acc_zero(accz0), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .shadow_valid(sv0), .restore_err(rerr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en       = 1'b0;
    acc_wr_mem  = 1'b0;
    acc_wr_alu  = 1'b0;
    ctx_save    = 1'b0;
    ctx_restore = 1'b0;
  endtask

  logic [DW-1:0] exp_regs [NR];

  initial begin
    rst = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    acc_din_mem = '0; acc_din_alu = '0;
    #12;
    chk("rst_rd_a", 32'(rda1), 32'h0);
    chk("rst_rd_b", 32'(rdb1), 32'h0);
    chk("rst_acc", 32'(acc1), 32'h0);
    chk("rst_acc_zero", 32'(accz1), 32'h1);
    chk("rst_shadow_valid", 32'(sv1), 32'h0);
    chk("rst_restore_err", 32'(rerr1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic writes and reads on both ports.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hA5A5;
    tick();
    wr_addr = 3'd2; wr_data = 16'h5A5A;
    tick();
    idle();
    rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    #1;
    chk("rd_a_r1", 32'(rda1), 32'hA5A5);
    chk("rd_b_r2", 32'(rdb1), 32'h5A5A);
    chk("nobyp_rd_b_r2", 32'(rdb0), 32'h5A5A);
    rd_addr_a = 3'd5; rd_addr_b = 3'd7;
    #1;
    chk("rd_a_oor", 32'(rda1), 32'h0);
    chk("rd_b_oor", 32'(rdb1), 32'h0);

    // An out-of-range write must leave every register unchanged.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hFFFF;
    tick();
    idle();
    exp_regs = '{16'h0000, 16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i);
      #1;
      chk($sformatf("oor_wr_r%0d", i), 32'(rda1), 32'(exp_regs[i]));
    end

    // Bypass on A versus pre-edge value, both ports on the same register.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    #1;
    chk("byp_rd_a", 32'(rda1), 32'hBEEF);
    chk("byp_rd_b", 32'(rdb1), 32'hBEEF);
    chk("nobyp_rd_a_pre", 32'(rda0), 32'h0000);
    tick();
    idle();
    #1;
    chk("nobyp_rd_a_post", 32'(rda0), 32'hBEEF);
    chk("byp_rd_a_post", 32'(rda1), 32'hBEEF);

    // The ALU source wins over memory when both are asserted.
    acc_wr_mem = 1'b1; acc_din_mem = 16'h1234; acc_wr_alu = 1'b1; acc_din_alu = 16'h0000;
    tick();
    chk("acc_prio", 32'(acc1), 32'h0000);
    chk("acc_prio_zero", 32'(accz1), 32'h1);
    acc_wr_alu = 1'b0;
    tick();
    idle();
    chk("acc_mem", 32'(acc1), 32'h1234);
    chk("acc_mem_zero", 32'(accz1), 32'h0);

    // Context save, overwrite, then restore with same-cycle writes that are dropped.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    acc_wr_alu = 1'b1; acc_din_alu = 16'h2222;
    tick();
    idle();
    ctx_save = 1'b1;
    tick();
    idle();
    chk("save_valid", 32'(sv1), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFACE;
    acc_wr_mem = 1'b1; acc_din_mem = 16'h0BAD;
    tick();
    idle();
    rd_addr_a = 3'd1;
    #1;
    chk("live_r1_face", 32'(rda1), 32'hFACE);
    chk("live_acc_0bad", 32'(acc1), 32'h0BAD);
    ctx_restore = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hDEAD;
    acc_wr_alu = 1'b1; acc_din_alu = 16'h7777;
    tick();
    idle();
    #1;
    chk("restore_r1", 32'(rda1), 32'h1111);
    chk("restore_acc", 32'(acc1), 32'h2222);
    chk("restore_acc_zero", 32'(accz1), 32'h0);
    chk("restore_valid_clr", 32'(sv1), 32'h0);
    chk("restore_no_err", 32'(rerr1), 32'h0);

    // A restore with no saved context raises the error for one cycle and changes nothing.
    ctx_restore = 1'b1;
    tick();
    idle();
    chk("err_pulse", 32'(rerr1), 32'h1);
    chk("err_r1_kept", 32'(rda1), 32'h1111);
    chk("err_acc_kept", 32'(acc1), 32'h2222);
    tick();
    chk("err_pulse_end", 32'(rerr1), 32'h0);

    // Save with a same-cycle write keeps the old value in the shadow.
    ctx_save = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hCAFE;
    tick();
    idle();
    rd_addr_b = 3'd2;
    #1;
    chk("save_wr_live", 32'(rdb1), 32'hCAFE);
    ctx_save = 1'b1; ctx_restore = 1'b1;
    tick();
    idle();
    #1;
    chk("sr_r2_restored", 32'(rdb1), 32'h5A5A);
    chk("sr_valid", 32'(sv1), 32'h0);
    chk("sr_no_err", 32'(rerr1), 32'h0);

    // Reset asserted in the middle of a cycle after a save.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFACE;
    tick();
    idle();
    ctx_save = 1'b1;
    tick();
    idle();
    chk("pre_rst_valid", 32'(sv1), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_r1", 32'(rda1), 32'h0);
    chk("midrst_r2", 32'(rdb1), 32'h0);
    chk("midrst_acc", 32'(acc1), 32'h0);
    chk("midrst_acc_zero", 32'(accz1), 32'h1);
    chk("midrst_valid", 32'(sv1), 32'h0);
    chk("midrst_nobyp_valid", 32'(sv0), 32'h0);
    chk("midrst_err", 32'(rerr1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
